spi_le_slave: RTL and testbench

- Responder end of the team's SPI link: receives frames from spi_master (spi_sclk / spi_mosi / active-low frame strobe spi_le) and returns a preloaded word on spi_miso.
- Oversamples all SPI inputs in the system clock domain. No SPI-clocked flops.
- Mode 0 only: CPOL=0, CPHA=0, MSB first.
- Sits between the SPI pins and the register/control logic. Delivers a right-justified received word plus its bit count per frame.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_sync_edge.sv | 31 +++
 rtl/spi_le_slave.sv | 179 +++++++++++++++++
 tb/tb_spi_le_slave.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI link state encoding, counter width and mode constants
package spi_pkg;

  localparam int BIT_CNT_W = 8;

  // Mode 0 link: sclk idles low, data sampled on the rising edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } spi_state_e;

  function automatic logic [BIT_CNT_W-1:0] sat_inc(input logic [BIT_CNT_W-1:0] cnt,
                                                   input logic [BIT_CNT_W-1:0] limit);
    return (cnt >= limit) ? limit : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-stage input synchronizer with rise/fall pulses
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_le_slave.sv
// rtl/spi_le_slave.sv - oversampled mode-0 SPI responder; SPI_LE_TIMEOUT_EN adds an in-frame idle abort
module spi_le_slave
  import spi_pkg::*;
#(
  parameter int DATA_DEPTH     = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_sclk,
  input  logic                  spi_mosi,
  input  logic                  spi_le,
  output logic                  spi_miso,
  input  logic [DATA_DEPTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_busy,
  output logic [DATA_DEPTH-1:0] rx_data,
  output logic [BIT_CNT_W-1:0]  rx_count,
  output logic                  rx_valid,
  output logic                  rx_err
);

  localparam logic [BIT_CNT_W-1:0] CNT_MAX = BIT_CNT_W'(DATA_DEPTH + 1);
  localparam logic [BIT_CNT_W-1:0] CNT_LIM = BIT_CNT_W'(DATA_DEPTH);

  logic sclk_sync, sclk_rise, sclk_fall;
  logic mosi_sync, mosi_rise, mosi_fall;
  logic le_sync, le_rise, le_fall;
  logic sample_edge, shift_edge;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(SPI_CPOL)) u_sync_sclk (
    .clk_i(clk), .rst_i(rst), .d_i(spi_sclk),
    .q_o(sclk_sync), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk_i(clk), .rst_i(rst), .d_i(spi_mosi),
    .q_o(mosi_sync), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_le (
    .clk_i(clk), .rst_i(rst), .d_i(spi_le),
    .q_o(le_sync), .rise_o(le_rise), .fall_o(le_fall)
  );

  assign sample_edge = SPI_CPHA ? sclk_fall : sclk_rise;
  assign shift_edge  = SPI_CPHA ? sclk_rise : sclk_fall;

  spi_state_e            state_q, state_d;
  logic [DATA_DEPTH-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_DEPTH-1:0] rx_sr_q, rx_sr_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_DEPTH-1:0] rx_data_q, rx_data_d;
  logic [BIT_CNT_W-1:0]  rx_count_q, rx_count_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  rx_err_q, rx_err_d;
  logic                  tx_busy_q, tx_busy_d;

`ifdef SPI_LE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_q, to_d;
  logic unused_sync;
  assign unused_sync = ^{sclk_sync, le_sync, mosi_rise, mosi_fall};
`else
  logic unused_sync;
  assign unused_sync = ^{sclk_sync, le_sync, mosi_rise, mosi_fall} ^ (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    state_d    = state_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    bit_cnt_d  = bit_cnt_q;
    rx_data_d  = rx_data_q;
    rx_count_d = rx_count_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    tx_busy_d  = tx_busy_q;
`ifdef SPI_LE_TIMEOUT_EN
    to_d       = to_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // A load coinciding with the frame start loses: the frame keeps the old word.
        if (le_fall) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = '0;
          rx_sr_d   = '0;
          tx_busy_d = 1'b1;
`ifdef SPI_LE_TIMEOUT_EN
          to_d      = '0;
`endif
        end else if (tx_load) begin
          tx_sr_d = tx_data;
        end
      end
      ST_SHIFT: begin
        if (sample_edge) begin
          rx_sr_d   = {rx_sr_q[DATA_DEPTH-2:0], mosi_sync};
          bit_cnt_d = sat_inc(bit_cnt_q, CNT_MAX);
        end
        if (shift_edge) begin
          tx_sr_d = {tx_sr_q[DATA_DEPTH-2:0], 1'b0};
        end
        if (le_rise) begin
          state_d = ST_DONE;
        end
`ifdef SPI_LE_TIMEOUT_EN
        if (sclk_rise || sclk_fall) begin
          to_d = '0;
        end else if (to_q == TO_LAST) begin
          // Stalled frame: drop it; the trailing le rise then lands in IDLE and is ignored.
          rx_err_d  = 1'b1;
          state_d   = ST_IDLE;
          tx_busy_d = 1'b0;
          to_d      = '0;
        end else begin
          to_d = to_q + 1'b1;
        end
`endif
      end
      ST_DONE: begin
        state_d   = ST_IDLE;
        tx_busy_d = 1'b0;
        if (bit_cnt_q > CNT_LIM) begin
          rx_err_d = 1'b1;
        end else if (bit_cnt_q != '0) begin
          rx_data_d  = rx_sr_q;
          rx_count_d = bit_cnt_q;
          rx_valid_d = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        tx_busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      bit_cnt_q  <= '0;
      rx_data_q  <= '0;
      rx_count_q <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      tx_busy_q  <= 1'b0;
`ifdef SPI_LE_TIMEOUT_EN
      to_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_data_q  <= rx_data_d;
      rx_count_q <= rx_count_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
      tx_busy_q  <= tx_busy_d;
`ifdef SPI_LE_TIMEOUT_EN
      to_q       <= to_d;
`endif
    end
  end

  assign spi_miso = tx_sr_q[DATA_DEPTH-1];
  assign tx_busy  = tx_busy_q;
  assign rx_data  = rx_data_q;
  assign rx_count = rx_count_q;
  assign rx_valid = rx_valid_q;
  assign rx_err   = rx_err_q;

endmodule

// File: tb/tb_spi_le_slave.sv
// tb/tb_spi_le_slave.sv - randomized frame-level model bench for spi_le_slave
`timescale 1ns/1ps
module tb_spi_le_slave;

  localparam int DW   = 16;
  localparam int SYNC = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          spi_sclk = 1'b0;
  logic          spi_mosi = 1'b0;
  logic          spi_le = 1'b1;
  logic          spi_miso;
  logic [DW-1:0] tx_data = '0;
  logic          tx_load = 1'b0;
  logic          tx_busy;
  logic [DW-1:0] rx_data;
  logic [7:0]    rx_count;
  logic          rx_valid;
  logic          rx_err;

  spi_le_slave #(.DATA_DEPTH(DW), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(1024)) dut (
    .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_le(spi_le),
    .spi_miso(spi_miso), .tx_data(tx_data), .tx_load(tx_load), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_count(rx_count), .rx_valid(rx_valid), .rx_err(rx_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            err;
    logic [DW-1:0] data;
    logic [7:0]    count;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] held_data;
  logic [7:0]    held_count;
  logic [DW-1:0] tx_model;
  int            n_checks = 0;
  int            n_fail = 0;
  int            n_valid_seen = 0;
  int            n_err_seen = 0;
  bit            mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Every cycle: pulses must match the frame queue, and held outputs must not drift.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held_data  = '0;
      held_count = '0;
      exp_q.delete();
    end else if (mon_en) begin
      if (rx_valid || rx_err) begin
        if (rx_valid) n_valid_seen++;
        if (rx_err)   n_err_seen++;
        check("pulse_exclusive", 32'(rx_valid & rx_err), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {30'd0, rx_valid, rx_err}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", 32'(rx_err), 32'(e.err));
          if (!e.err) begin
            check("rx_data", 32'(rx_data), 32'(e.data));
            check("rx_count", 32'(rx_count), 32'(e.count));
            held_data  = e.data;
            held_count = e.count;
          end else begin
            check("err_keeps_data", 32'(rx_data), 32'(held_data));
            check("err_keeps_count", 32'(rx_count), 32'(held_count));
          end
        end
      end else begin
        check("rx_data_hold", 32'(rx_data), 32'(held_data));
        check("rx_count_hold", 32'(rx_count), 32'(held_count));
      end
    end
  end

  task automatic load_tx(input logic [DW-1:0] w);
    tx_data = w;
    tx_load = 1'b1;
    @(posedge clk); #1;
    tx_load = 1'b0;
    tx_model = w;
  endtask

  // Master side of one frame; each sclk phase lasts `phase` clk cycles.
  task automatic run_frame(input int n, input logic [31:0] bits, input int phase,
                           input bit load_at_fall, input logic [DW-1:0] lf_word,
                           output logic [31:0] miso_word);
    exp_t        e;
    logic [31:0] m;
    logic [31:0] exp_miso;
    int          lat;
    miso_word = '0;
    exp_miso  = '0;
    if (n > 0) begin
      m       = (32'd1 << n) - 32'd1;
      e.err   = (n > DW);
      e.count = 8'(n);
      e.data  = DW'(bits & m);
      exp_q.push_back(e);
    end
    spi_le = 1'b0;
    if (load_at_fall) begin
      repeat (2) @(posedge clk); #1;
      tx_data = lf_word;
      tx_load = 1'b1;
      @(posedge clk); #1;
      tx_load = 1'b0;
      @(posedge clk); #1;
    end else begin
      repeat (4) @(posedge clk); #1;
    end
    for (int i = 0; i < n; i++) begin
      spi_mosi = bits[n-1-i];
      repeat (phase) @(posedge clk); #1;
      miso_word = {miso_word[30:0], spi_miso};
      exp_miso  = {exp_miso[30:0], (i < DW) ? tx_model[DW-1-i] : 1'b0};
      if (i == 0) check("tx_busy_in_frame", 32'(tx_busy), 32'd1);
      spi_sclk = 1'b1;
      repeat (phase) @(posedge clk); #1;
      spi_sclk = 1'b0;
    end
    repeat (phase) @(posedge clk); #1;
    spi_le = 1'b1;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (rx_valid || rx_err) begin
        lat = k;
        break;
      end
    end
    if (n > 0) check("pulse_latency", 32'(lat), 32'(SYNC + 2));
    repeat (4) @(posedge clk); #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    if (exp_q.size() != 0) exp_q.delete();
    check("tx_busy_idle", 32'(tx_busy), 32'd0);
    if (phase >= 3 && n > 0) check("miso_word", miso_word, exp_miso);
    tx_model = (n >= DW) ? '0 : (tx_model << n);
  endtask

  initial begin
    exp_t        e;
    logic [31:0] mw;
    int          v0, e0, n, ph;
    logic [31:0] bits;
    tx_model = '0;

    repeat (3) @(posedge clk); #1;
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_count", 32'(rx_count), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_err", 32'(rx_err), 32'd0);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    check("rst_miso", 32'(spi_miso), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (4) @(posedge clk); #1;

    run_frame(16, 32'h0000_aabb, 2, 1'b0, '0, mw);
    check("aabb_data", 32'(rx_data), 32'h0000_aabb);
    check("aabb_count", 32'(rx_count), 32'd16);

    load_tx(16'h1234);
    run_frame(16, 32'h0000_0f0f, 4, 1'b0, '0, mw);
    check("miso_1234", mw, 32'h0000_1234);

    run_frame(8, 32'h0000_005a, 3, 1'b0, '0, mw);
    check("5a_data", 32'(rx_data), 32'h0000_005a);
    check("5a_count", 32'(rx_count), 32'd8);

    v0 = n_valid_seen; e0 = n_err_seen;
    run_frame(17, 32'h0001_ffff, 2, 1'b0, '0, mw);
    check("ovf_err_pulses", 32'(n_err_seen - e0), 32'd1);
    check("ovf_no_valid", 32'(n_valid_seen - v0), 32'd0);
    check("ovf_keeps_data", 32'(rx_data), 32'h0000_005a);

    v0 = n_valid_seen; e0 = n_err_seen;
    run_frame(0, 32'h0, 2, 1'b0, '0, mw);
    check("empty_no_valid", 32'(n_valid_seen - v0), 32'd0);
    check("empty_no_err", 32'(n_err_seen - e0), 32'd0);

    load_tx(16'hc3a5);
    run_frame(16, 32'h0000_9999, 4, 1'b1, 16'hffff, mw);
    check("load_at_fall_ignored", mw, 32'h0000_c3a5);

    // Reset in the middle of a frame, with miso and rx_data both non-zero beforehand.
    load_tx(16'hffff);
    spi_le = 1'b0;
    repeat (4) @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      spi_mosi = 1'b1;
      repeat (2) @(posedge clk); #1;
      spi_sclk = 1'b1;
      repeat (2) @(posedge clk); #1;
      spi_sclk = 1'b0;
    end
    repeat (4) @(posedge clk); #1;
    rst = 1'b1;
    spi_le = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("midrst_miso", 32'(spi_miso), 32'd0);
    check("midrst_busy", 32'(tx_busy), 32'd0);
    check("midrst_rx_data", 32'(rx_data), 32'd0);
    check("midrst_rx_count", 32'(rx_count), 32'd0);
    check("midrst_valid", 32'(rx_valid), 32'd0);
    check("midrst_err", 32'(rx_err), 32'd0);
    rst = 1'b0;
    tx_model = '0;
    repeat (8) @(posedge clk); #1;
    check("post_rst_busy", 32'(tx_busy), 32'd0);

    // Stall with sclk frozen mid-frame.
    load_tx(16'h8001);
    spi_le = 1'b0;
    repeat (4) @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      spi_mosi = (i != 1);
      repeat (2) @(posedge clk); #1;
      spi_sclk = 1'b1;
      repeat (2) @(posedge clk); #1;
      spi_sclk = 1'b0;
    end
`ifdef SPI_LE_TIMEOUT_EN
    e.err = 1'b1; e.data = '0; e.count = '0;
    exp_q.push_back(e);
`endif
    repeat (1100) @(posedge clk); #1;
`ifdef SPI_LE_TIMEOUT_EN
    check("timeout_pulse_seen", 32'(exp_q.size()), 32'd0);
    check("timeout_idle_busy", 32'(tx_busy), 32'd0);
`else
    check("stall_still_busy", 32'(tx_busy), 32'd1);
    e.err = 1'b0; e.data = 16'h0005; e.count = 8'd3;
    exp_q.push_back(e);
`endif
    spi_le = 1'b1;
    repeat (12) @(posedge clk); #1;
    check("stall_drained", 32'(exp_q.size()), 32'd0);
    if (exp_q.size() != 0) exp_q.delete();
    check("stall_end_busy", 32'(tx_busy), 32'd0);
    tx_model = tx_model << 3;

    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 1) == 1) load_tx(DW'($urandom));
      n    = $urandom_range(0, 18);
      ph   = $urandom_range(2, 4);
      bits = $urandom;
      run_frame(n, bits, ph, 1'b0, '0, mw);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
